uart_tx: RTL



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 47 ++++
 rtl/uart_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//
// Contents:
//   DFIFO_DATA_WIDTH     - width of the data FIFO words (one UART frame payload)
//   UART_BAUD_DIV_WIDTH  - width of the baud divisor register
//   uart_tx_state_t      - transmit FSM state encoding
//   uart_parity          - parity bit helper (even = XOR of data, odd = inverse)
package uart_pkg;

    localparam int DFIFO_DATA_WIDTH    = 8;
    localparam int UART_BAUD_DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    function automatic logic uart_parity(
        input logic [DFIFO_DATA_WIDTH-1:0] data,
        input logic                        odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART TX and RX paths.
//
// The divisor is captured on load, so the caller may change its divisor
// input freely afterwards. The counter starts from the divisor, counts
// down to 0 and reloads, giving a bit period of divisor+1 clocks.
// A divisor of 0 therefore gives one tick every clock.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   load     in   capture divisor and restart the bit period
//   divisor  in   bit period minus one, in clocks
//   tick     out  high in the last clock of each bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = UART_BAUD_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_q <= divisor;
            cnt   <= divisor;
        end else if (cnt == '0) begin
            cnt   <= div_q;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end

    // The owner ignores tick outside its timed states, so the counter is
    // left free-running between frames instead of being gated.
    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmit engine.
//
// Pops one byte at a time from the data FIFO and sends it as a start bit,
// DATA_WIDTH data bits LSB first, an optional parity bit and one or two
// stop bits. Divisor and frame format are latched when the byte is loaded,
// so configuration changes only affect the next frame.
//
// Optional feature: define UART_TX_PARITY_EN to build the parity state and
// generator. Without it the parity ports are ignored and every frame is
// 8N1 or 8N2.
//
// Ports:
//   i_clk             in   clock
//   i_rst             in   asynchronous active-high reset
//   i_tx_en           in   transmit enable; low blocks new frames only
//   i_baud_div        in   bit period = i_baud_div + 1 clocks
//   i_stop2           in   0 = one stop bit, 1 = two stop bits
//   i_parity_en       in   append parity bit (UART_TX_PARITY_EN builds only)
//   i_parity_odd      in   0 = even parity, 1 = odd parity
//   i_dfifo_empty     in   data FIFO empty flag
//   i_dfifo_data      in   data FIFO output, valid the cycle after a pop
//   o_dfifo_read_req  out  single-cycle pop request
//   o_tx              out  serial line, registered, idle high
//   o_tx_status       out  busy: high whenever the FSM is not idle
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DFIFO_DATA_WIDTH,
    parameter int BAUD_DIV_WIDTH = UART_BAUD_DIV_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_tx_en,
    input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
    input  logic                      i_stop2,
    input  logic                      i_parity_en,
    input  logic                      i_parity_odd,
    input  logic                      i_dfifo_empty,
    input  logic [DATA_WIDTH-1:0]     i_dfifo_data,
    output logic                      o_dfifo_read_req,
    output logic                      o_tx,
    output logic                      o_tx_status
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    uart_tx_state_t state, state_d;

    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
    logic                  stop_cnt, stop_cnt_d;
    logic                  stop2_q;
    logic                  tx_q, tx_d;
    logic                  tick;
    logic                  bit_last;
    logic                  stop_last;
    logic                  parity_next;

    // ------------------------------------------------------------------
    // Bit timing
    // ------------------------------------------------------------------
    uart_baud_gen #(
        .DIV_WIDTH (BAUD_DIV_WIDTH)
    ) u_baud_gen (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (state == ST_LOAD),
        .divisor (i_baud_div),
        .tick    (tick)
    );

    assign bit_last  = (bit_cnt == BIT_LAST);
    // Second stop bit is needed only when two were requested and the
    // first one has already been sent.
    assign stop_last = !stop2_q || stop_cnt;

    // ------------------------------------------------------------------
    // Optional parity
    // ------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_q;

    // Parity is computed once from the loaded byte; the shift register
    // is destroyed while sending, so it cannot be derived later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else if (state == ST_LOAD) begin
            par_en_q <= i_parity_en;
            par_q    <= (^i_dfifo_data) ^ i_parity_odd;
        end
    end

    assign parity_next = par_en_q;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = i_parity_en ^ i_parity_odd;
    assign parity_next       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                // Pops are only ever requested from FETCH, so gating the
                // entry here is what keeps an empty FIFO from being read.
                if (i_tx_en && !i_dfifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && bit_last) begin
                    state_d = parity_next ? ST_PARITY : ST_STOP;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick && stop_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register and bit counters
    // ------------------------------------------------------------------
    always_comb begin
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        case (state)
            ST_LOAD: begin
                shreg_d    = i_dfifo_data;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d   = shreg >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
            if (state == ST_LOAD) begin
                stop2_q <= i_stop2;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // The line is registered, so its next value is decoded from the next
    // state and next shift-register contents; this makes o_tx change on
    // the same edge the FSM enters each bit.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign o_tx             = tx_q;
    assign o_dfifo_read_req = (state == ST_FETCH);
    assign o_tx_status      = (state != ST_IDLE);

endmodule
